bitseq_player_mc: RTL and testbench

Multi-channel pattern player: an NCH-bit-wide sequence RAM is loaded while idle and then replayed onto NCH parallel output pins, one word every rate_div+1 clocks. Playback starts after a programmable delay and runs for a programmable number of passes, or endlessly. Each channel has its own enable, inversion and idle level. The block sits behind the host register file and drives the pattern-generator pins of the debugger; it supersedes the single-channel, single-mode player.

---
 rtl/bitseq_pkg.sv | 23 ++
 rtl/bitseq_player_mc_if.sv | 41 ++++
 rtl/bitseq_mem.sv | 33 +++
 rtl/bitseq_player_mc.sv | 175 +++++++++++++++++
 tb/tb_bitseq_player_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitseq_pkg.sv
// Shared types, default sizes and the per-channel output mapping for the
// multi-channel bit-sequence player.
package bitseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PLAY  = 2'd2
  } state_t;

  localparam int NCH_DEF = 4;
  localparam int AW_DEF  = 12;
  localparam int LW_DEF  = 16;

  // Enabled channels show (possibly inverted) data, disabled ones their idle level.
  function automatic logic [31:0] map_out(input logic [31:0] word,
                                          input logic [31:0] en,
                                          input logic [31:0] inv,
                                          input logic [31:0] idle);
    return (en & (word ^ inv)) | (~en & idle);
  endfunction

endpackage

// File: rtl/bitseq_player_mc_if.sv
// Host-side register/control bundle of the bit-sequence player.
interface bitseq_player_mc_if
  import bitseq_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int AW  = AW_DEF,
  parameter int LW  = LW_DEF
);

  logic            start_trig;
  logic            stop;
  logic [AW:0]     len;
  logic [31:0]     rate_div;
  logic [31:0]     phase_off;
  logic [LW-1:0]   loop_cnt;
  logic [NCH-1:0]  ch_en;
  logic [NCH-1:0]  ch_inv;
  logic [NCH-1:0]  idle_lvl;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [NCH-1:0]  wr_data;
  logic [NCH-1:0]  wr_mask;
  logic [NCH-1:0]  io_out;
  logic            playing;
  logic            done;
  logic            wr_err;
  logic [LW-1:0]   pass_idx;

  modport master (
    output start_trig, stop, len, rate_div, phase_off, loop_cnt,
           ch_en, ch_inv, idle_lvl, wr_en, wr_addr, wr_data, wr_mask,
    input  io_out, playing, done, wr_err, pass_idx
  );

  modport slave (
    input  start_trig, stop, len, rate_div, phase_off, loop_cnt,
           ch_en, ch_inv, idle_lvl, wr_en, wr_addr, wr_data, wr_mask,
    output io_out, playing, done, wr_err, pass_idx
  );

endinterface

// File: rtl/bitseq_mem.sv
// Simple dual-port sequence RAM with per-bit write enable and registered read.
module bitseq_mem
  import bitseq_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int AW  = AW_DEF
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [NCH-1:0] wr_data,
  input  logic [NCH-1:0] wr_mask,
  input  logic           rd_en,
  input  logic [AW-1:0]  rd_addr,
  output logic [NCH-1:0] rd_data
);

  logic [NCH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_mask[i]) mem[wr_addr][i] <= wr_data[i];
      end
    end
  end

  // No reset on the read port so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bitseq_player_mc.sv
// Multi-channel pattern player: replays the sequence RAM onto NCH pins with
// programmable start delay, word period and pass count.
module bitseq_player_mc
  import bitseq_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int AW  = AW_DEF,
  parameter int LW  = LW_DEF
) (
  input logic               clk,
  input logic               rst_n,
  bitseq_player_mc_if.slave bus
);

  state_t         state_reg, state_next;
  logic [AW:0]    len_reg;
  logic [31:0]    rate_reg, phase_reg;
  logic [LW-1:0]  loop_reg;
  logic [NCH-1:0] en_reg, inv_reg;
  logic [31:0]    dly_cnt_reg, dly_cnt_next;
  logic [31:0]    div_cnt_reg, div_cnt_next;
  logic [AW:0]    load_idx_reg, load_idx_next, idx_inc, next_idx;
  logic           last_reg, last_next;
  logic           prime_reg;
  logic           active_reg, active_next;
  logic [NCH-1:0] cur_word_reg, cur_word_next;
  logic [NCH-1:0] io_out_reg, io_out_next;
  logic           playing_reg, playing_next;
  logic           done_reg, done_next;
  logic           wr_err_reg, wr_err_next;
  logic [LW-1:0]  pass_idx_reg, pass_idx_next;

  logic           start_ok, start_go, hold_done, first_load;
  logic           pass_end, more_passes, finish, load;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [NCH-1:0] rd_data;

  bitseq_mem #(.NCH(NCH), .AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (bus.wr_en && !playing_reg),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .wr_mask (bus.wr_mask),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Shared decode used by both the next-state and the output processes.
  always_comb begin
    start_ok    = bus.start_trig && !bus.stop && (bus.len != '0);
    hold_done   = active_reg && (div_cnt_reg == rate_reg);
    first_load  = (state_reg == PLAY) && !prime_reg && !active_reg;
    pass_end    = hold_done && last_reg;
    more_passes = (loop_reg == '0) ||
                  (((LW+1)'(pass_idx_reg) + (LW+1)'(1)) < (LW+1)'(loop_reg));
    finish      = pass_end && !more_passes;
    load        = (state_reg == PLAY) && !bus.stop &&
                  (first_load || (hold_done && !finish));
    idx_inc     = load_idx_reg + (AW+1)'(1);
    next_idx    = (idx_inc == len_reg) ? '0 : idx_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = (bus.phase_off != '0) ? DELAY : PLAY;
      DELAY:   if (bus.stop) state_next = IDLE;
               else if (dly_cnt_reg == phase_reg) state_next = PLAY;
      PLAY:    if (bus.stop || finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The read port runs one word ahead: word k+1 is fetched on the edge that
  // puts word k on the pins, so rd_data is ready at the next load.
  always_comb begin
    start_go      = (state_reg == IDLE) && start_ok;
    rd_en         = start_go || load;
    rd_addr       = start_go ? '0 : next_idx[AW-1:0];
    load_idx_next = load_idx_reg;
    last_next     = last_reg;
    cur_word_next = cur_word_reg;
    div_cnt_next  = div_cnt_reg;
    dly_cnt_next  = dly_cnt_reg;
    pass_idx_next = pass_idx_reg;

    if (start_go) begin
      load_idx_next = '0;
      last_next     = 1'b0;
      dly_cnt_next  = 32'd1;
      pass_idx_next = '0;
    end
    if (state_reg == DELAY) dly_cnt_next = dly_cnt_reg + 32'd1;

    if (load) begin
      load_idx_next = next_idx;
      last_next     = (load_idx_reg == len_reg - (AW+1)'(1));
      cur_word_next = rd_data;
      div_cnt_next  = '0;
    end else if (active_reg) begin
      div_cnt_next  = div_cnt_reg + 32'd1;
    end

    if ((state_reg == PLAY) && !bus.stop && pass_end)
      pass_idx_next = pass_idx_reg + LW'(1);

    active_next  = (state_next == PLAY) && (active_reg || load);
    io_out_next  = active_next ?
                   NCH'(map_out(32'(cur_word_next), 32'(en_reg), 32'(inv_reg), 32'(bus.idle_lvl))) :
                   bus.idle_lvl;
    playing_next = (state_next != IDLE);
    done_next    = ((state_reg == IDLE) && bus.start_trig && !bus.stop && (bus.len == '0)) ||
                   ((state_reg == PLAY) && !bus.stop && finish);
    wr_err_next  = bus.wr_en && playing_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg      <= '0;
      rate_reg     <= '0;
      phase_reg    <= '0;
      loop_reg     <= '0;
      en_reg       <= '0;
      inv_reg      <= '0;
      dly_cnt_reg  <= '0;
      div_cnt_reg  <= '0;
      load_idx_reg <= '0;
      last_reg     <= 1'b0;
      prime_reg    <= 1'b1;
      active_reg   <= 1'b0;
      cur_word_reg <= '0;
      io_out_reg   <= '0;
      playing_reg  <= 1'b0;
      done_reg     <= 1'b0;
      wr_err_reg   <= 1'b0;
      pass_idx_reg <= '0;
    end else begin
      if (start_go) begin
        len_reg   <= bus.len;
        rate_reg  <= bus.rate_div;
        phase_reg <= bus.phase_off;
        loop_reg  <= bus.loop_cnt;
        en_reg    <= bus.ch_en;
        inv_reg   <= bus.ch_inv;
      end
      dly_cnt_reg  <= dly_cnt_next;
      div_cnt_reg  <= div_cnt_next;
      load_idx_reg <= load_idx_next;
      last_reg     <= last_next;
      // First PLAY cycle waits for the prefetched word to settle.
      prime_reg    <= (state_reg != PLAY);
      active_reg   <= active_next;
      cur_word_reg <= cur_word_next;
      io_out_reg   <= io_out_next;
      playing_reg  <= playing_next;
      done_reg     <= done_next;
      wr_err_reg   <= wr_err_next;
      pass_idx_reg <= pass_idx_next;
    end
  end

  assign bus.io_out   = io_out_reg;
  assign bus.playing  = playing_reg;
  assign bus.done     = done_reg;
  assign bus.wr_err   = wr_err_reg;
  assign bus.pass_idx = pass_idx_reg;

endmodule

// File: tb/tb_bitseq_player_mc.sv
// Directed self-checking bench for bitseq_player_mc (NCH=4, AW=4).
module tb_bitseq_player_mc;

  localparam int NCH = 4;
  localparam int AW  = 4;
  localparam int LW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bitseq_player_mc_if #(.NCH(NCH), .AW(AW), .LW(LW)) bif();

  bitseq_player_mc #(.NCH(NCH), .AW(AW), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.start_trig = 1'b0;
    bif.stop       = 1'b0;
    bif.len        = '0;
    bif.rate_div   = '0;
    bif.phase_off  = '0;
    bif.loop_cnt   = '0;
    bif.ch_en      = '0;
    bif.ch_inv     = '0;
    bif.idle_lvl   = '0;
    bif.wr_en      = 1'b0;
    bif.wr_addr    = '0;
    bif.wr_data    = '0;
    bif.wr_mask    = '0;
  endtask

  task automatic wr(input int addr, input logic [3:0] data, input logic [3:0] mask);
    bif.wr_en   = 1'b1;
    bif.wr_addr = addr[AW-1:0];
    bif.wr_data = data;
    bif.wr_mask = mask;
    tick();
    bif.wr_en   = 1'b0;
  endtask

  task automatic cfg(input int len, input int rate, input int phase, input int loops,
                     input logic [3:0] en, input logic [3:0] inv, input logic [3:0] idle);
    bif.len       = (AW+1)'(len);
    bif.rate_div  = rate;
    bif.phase_off = phase;
    bif.loop_cnt  = LW'(loops);
    bif.ch_en     = en;
    bif.ch_inv    = inv;
    bif.idle_lvl  = idle;
  endtask

  task automatic pulse_start();
    bif.start_trig = 1'b1;
    tick();
    bif.start_trig = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bif.io_out !== 4'h0 || bif.playing !== 1'b0 || bif.done !== 1'b0 ||
        bif.wr_err !== 1'b0 || bif.pass_idx !== 16'd0) begin
      errors++;
      $display("FAIL reset_values io=%h playing=%b done=%b wr_err=%b pass=%0d required all zero",
               bif.io_out, bif.playing, bif.done, bif.wr_err, bif.pass_idx);
    end
    bif.idle_lvl = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bif.io_out !== 4'b1001) begin
      errors++;
      $display("FAIL idle_tracking io=%h required 9", bif.io_out);
    end
    bif.idle_lvl = 4'h0;
    tick();
    $display("test_reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_basic();
    logic [3:0] w [4];
    logic [3:0] exp_io;
    w = '{4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < 4; i++) wr(i, w[i], 4'hF);
    cfg(4, 2, 0, 1, 4'hF, 4'h0, 4'h0);
    pulse_start();
    checks++;
    if (bif.playing !== 1'b1 || bif.io_out !== 4'h0) begin
      errors++;
      $display("FAIL basic_accept playing=%b io=%h required 1/0", bif.playing, bif.io_out);
    end
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp_io = (c >= 2 && c < 14) ? w[(c - 2) / 3] : 4'h0;
      checks++;
      if (bif.io_out !== exp_io || bif.playing !== (c < 14) || bif.done !== (c == 14)) begin
        errors++;
        $display("FAIL basic c=%0d io=%h playing=%b done=%b required io=%h playing=%b done=%b",
                 c, bif.io_out, bif.playing, bif.done, exp_io, c < 14, c == 14);
      end
    end
    $display("test_basic: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_loop();
    logic [3:0] w [3];
    logic [3:0] exp_io;
    int         exp_pass;
    w = '{4'h3, 4'h5, 4'h9};
    for (int i = 0; i < 3; i++) wr(i, w[i], 4'hF);
    cfg(3, 0, 5, 0, 4'hF, 4'h0, 4'h0);
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      tick();
      exp_io   = (c >= 7) ? w[(c - 7) % 3] : 4'h0;
      exp_pass = (c >= 7) ? (c - 7) / 3 : 0;
      checks++;
      if (bif.io_out !== exp_io || bif.pass_idx !== 16'(exp_pass) || bif.playing !== 1'b1) begin
        errors++;
        $display("FAIL loop c=%0d io=%h pass=%0d playing=%b required io=%h pass=%0d playing=1",
                 c, bif.io_out, bif.pass_idx, bif.playing, exp_io, exp_pass);
      end
    end
    bif.stop = 1'b1;
    tick();
    bif.stop = 1'b0;
    checks++;
    if (bif.io_out !== 4'h0 || bif.playing !== 1'b0 || bif.done !== 1'b0 || bif.pass_idx !== 16'd3) begin
      errors++;
      $display("FAIL loop_stop io=%h playing=%b done=%b pass=%0d required 0/0/0/3",
               bif.io_out, bif.playing, bif.done, bif.pass_idx);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bif.done !== 1'b0 || bif.io_out !== 4'h0) begin
        errors++;
        $display("FAIL loop_after_stop done=%b io=%h required 0/0", bif.done, bif.io_out);
      end
    end
    $display("test_loop: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_channels();
    logic [3:0] exp_io;
    wr(0, 4'hF, 4'hF);
    cfg(1, 1, 2, 1, 4'b1010, 4'b0010, 4'b0101);
    tick();
    checks++;
    if (bif.io_out !== 4'b0101) begin
      errors++;
      $display("FAIL chan_idle io=%b required 0101", bif.io_out);
    end
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_io = (c == 4 || c == 5) ? 4'b1101 : 4'b0101;
      checks++;
      if (bif.io_out !== exp_io || bif.done !== (c == 6)) begin
        errors++;
        $display("FAIL chan c=%0d io=%b done=%b required io=%b done=%b",
                 c, bif.io_out, bif.done, exp_io, c == 6);
      end
      if (c == 4) begin
        bif.ch_en  = 4'hF;
        bif.ch_inv = 4'h0;
      end
    end
    $display("test_channels: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_write_protect();
    wr(0, 4'hF, 4'hF);
    checks++;
    if (bif.wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wp_idle_write wr_err=%b required 0", bif.wr_err);
    end
    cfg(1, 3, 0, 2, 4'hF, 4'h0, 4'h0);
    pulse_start();
    bif.wr_en   = 1'b1;
    bif.wr_addr = '0;
    bif.wr_data = 4'h0;
    bif.wr_mask = 4'hF;
    tick();
    bif.wr_en   = 1'b0;
    checks++;
    if (bif.wr_err !== 1'b1) begin
      errors++;
      $display("FAIL wp_err_pulse wr_err=%b required 1", bif.wr_err);
    end
    tick();
    checks++;
    if (bif.wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wp_err_clear wr_err=%b required 0", bif.wr_err);
    end
    for (int i = 0; i < 40 && bif.playing; i++) tick();
    checks++;
    if (bif.playing !== 1'b0) begin
      errors++;
      $display("FAIL wp_end_timeout playing=%b required 0", bif.playing);
    end
    cfg(1, 0, 0, 1, 4'hF, 4'h0, 4'h0);
    pulse_start();
    tick();
    tick();
    checks++;
    if (bif.io_out !== 4'hF) begin
      errors++;
      $display("FAIL wp_word_kept io=%h required f", bif.io_out);
    end
    tick();
    wr(0, 4'h0, 4'b0011);
    pulse_start();
    tick();
    tick();
    checks++;
    if (bif.io_out !== 4'b1100) begin
      errors++;
      $display("FAIL wp_masked io=%b required 1100", bif.io_out);
    end
    tick();
    $display("test_write_protect: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_boundary();
    logic [3:0] exp_io;
    cfg(0, 0, 0, 1, 4'hF, 4'h0, 4'h0);
    pulse_start();
    checks++;
    if (bif.done !== 1'b1 || bif.playing !== 1'b0) begin
      errors++;
      $display("FAIL len0_done done=%b playing=%b required 1/0", bif.done, bif.playing);
    end
    tick();
    checks++;
    if (bif.done !== 1'b0 || bif.playing !== 1'b0) begin
      errors++;
      $display("FAIL len0_after done=%b playing=%b required 0/0", bif.done, bif.playing);
    end

    cfg(4, 0, 0, 1, 4'hF, 4'h0, 4'h0);
    bif.start_trig = 1'b1;
    bif.stop       = 1'b1;
    tick();
    bif.start_trig = 1'b0;
    bif.stop       = 1'b0;
    checks++;
    if (bif.playing !== 1'b0 || bif.done !== 1'b0) begin
      errors++;
      $display("FAIL start_stop playing=%b done=%b required 0/0", bif.playing, bif.done);
    end
    tick();
    tick();
    checks++;
    if (bif.playing !== 1'b0 || bif.io_out !== 4'h0) begin
      errors++;
      $display("FAIL start_stop_later playing=%b io=%h required 0/0", bif.playing, bif.io_out);
    end

    for (int i = 0; i < 16; i++) wr(i, 4'(i), 4'hF);
    cfg(16, 0, 0, 2, 4'hF, 4'h0, 4'h0);
    pulse_start();
    for (int c = 1; c <= 35; c++) begin
      tick();
      exp_io = (c >= 2 && c < 34) ? 4'((c - 2) % 16) : 4'h0;
      checks++;
      if (bif.io_out !== exp_io || bif.playing !== (c < 34) || bif.done !== (c == 34)) begin
        errors++;
        $display("FAIL full_depth c=%0d io=%h playing=%b done=%b required io=%h playing=%b done=%b",
                 c, bif.io_out, bif.playing, bif.done, exp_io, c < 34, c == 34);
      end
      if (c == 18 || c == 34) begin
        checks++;
        if (bif.pass_idx !== ((c == 18) ? 16'd1 : 16'd2)) begin
          errors++;
          $display("FAIL full_depth_pass c=%0d pass=%0d required %0d",
                   c, bif.pass_idx, (c == 18) ? 1 : 2);
        end
      end
    end

    cfg(4, 0, 3, 0, 4'hF, 4'h0, 4'b0110);
    pulse_start();
    for (int c = 1; c <= 12; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bif.io_out !== 4'h0 || bif.playing !== 1'b0 || bif.done !== 1'b0 ||
        bif.wr_err !== 1'b0 || bif.pass_idx !== 16'd0) begin
      errors++;
      $display("FAIL async_reset io=%h playing=%b done=%b wr_err=%b pass=%0d required all zero",
               bif.io_out, bif.playing, bif.done, bif.wr_err, bif.pass_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bif.io_out !== 4'b0110 || bif.playing !== 1'b0) begin
      errors++;
      $display("FAIL after_reset io=%b playing=%b required 0110/0", bif.io_out, bif.playing);
    end
    $display("test_boundary: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_channels();
    test_write_protect();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
